// File: rtl/wbu.sv
// Writeback unit: captures one retiring instruction per handshake, waits for load data and
// emits a single-cycle register-file write / commit pulse. WBU_FWD_EN adds pend_* outputs.
module wbu #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_pc_i,
   input  logic [ADDR_WIDTH-1:0] in_rd_i,
   input  logic                  in_rd_wen_i,
   input  logic [1:0]            in_sel_i,
   input  logic [DATA_WIDTH-1:0] in_alu_result_i,
   input  logic [2:0]            in_mem_op_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  rf_wen_o,
   output logic [ADDR_WIDTH-1:0] rf_rd_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  commit_valid_o,
   output logic [DATA_WIDTH-1:0] commit_pc_o
`ifdef WBU_FWD_EN
   ,
   output logic                  pend_valid_o,
   output logic [ADDR_WIDTH-1:0] pend_rd_o
`endif
);

   typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

   state_e                  state_q;
   logic [DATA_WIDTH-1:0]   pc_q;
   logic [ADDR_WIDTH-1:0]   rd_q;
   logic                    rd_wen_q;
   logic [1:0]              off_q;
   logic [2:0]              mem_op_q;

   logic                    rf_wen_q;
   logic [ADDR_WIDTH-1:0]   rf_rd_q;
   logic [DATA_WIDTH-1:0]   rf_wdata_q;
   logic                    commit_valid_q;
   logic [DATA_WIDTH-1:0]   commit_pc_q;

   logic                    hs;
   logic [DATA_WIDTH-1:0]   in_result;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [DATA_WIDTH-1:0]   load_data;

   assign in_ready_o = (state_q != StWaitMem);
   assign hs         = in_valid_i && in_ready_o;
   assign in_result  = (in_sel_i == 2'd2) ? in_pc_i + DATA_WIDTH'(4) : in_alu_result_i;

   // Halfword selection uses addr[1] only; addr[0] is deliberately ignored.
   always_comb begin
      byte_sel  = mem_rdata_i[{off_q, 3'b000} +: 8];
      half_sel  = off_q[1] ? mem_rdata_i[16 +: 16] : mem_rdata_i[0 +: 16];
      load_data = mem_rdata_i;
      case (mem_op_q)
         3'd0:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'd1:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'd4:    load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'd5:    load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_data = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         pc_q           <= '0;
         rd_q           <= '0;
         rd_wen_q       <= 1'b0;
         off_q          <= '0;
         mem_op_q       <= '0;
         rf_wen_q       <= 1'b0;
         rf_rd_q        <= '0;
         rf_wdata_q     <= '0;
         commit_valid_q <= 1'b0;
         commit_pc_q    <= '0;
      end else begin
         rf_wen_q       <= 1'b0;
         commit_valid_q <= 1'b0;
         unique case (state_q)
            StIdle, StWrite: begin
               if (hs) begin
                  pc_q     <= in_pc_i;
                  rd_q     <= in_rd_i;
                  rd_wen_q <= in_rd_wen_i;
                  off_q    <= in_alu_result_i[1:0];
                  mem_op_q <= in_mem_op_i;
                  if (in_sel_i == 2'd1) begin
                     state_q <= StWaitMem;
                  end else begin
                     state_q        <= StWrite;
                     rf_wen_q       <= in_rd_wen_i && (in_rd_i != '0);
                     rf_rd_q        <= in_rd_i;
                     rf_wdata_q     <= in_result;
                     commit_valid_q <= 1'b1;
                     commit_pc_q    <= in_pc_i;
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StWaitMem: begin
               if (mem_rvalid_i) begin
                  state_q        <= StWrite;
                  rf_wen_q       <= rd_wen_q && (rd_q != '0);
                  rf_rd_q        <= rd_q;
                  rf_wdata_q     <= load_data;
                  commit_valid_q <= 1'b1;
                  commit_pc_q    <= pc_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rf_wen_o       = rf_wen_q;
   assign rf_rd_o        = rf_rd_q;
   assign rf_wdata_o     = rf_wdata_q;
   assign commit_valid_o = commit_valid_q;
   assign commit_pc_o    = commit_pc_q;

`ifdef WBU_FWD_EN
   assign pend_valid_o = (state_q != StIdle) && rd_wen_q && (rd_q != '0);
   assign pend_rd_o    = rd_q;
`endif

endmodule

// File: tb/tb_wbu.sv
// Randomized bench for wbu: drives directed then random instructions and checks every cycle
// against a transaction-level model of expected commits.
module tb_wbu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic [1:0]  in_sel;
   logic [31:0] in_alu_result;
   logic [2:0]  in_mem_op;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_wen;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        commit_valid;
   logic [31:0] commit_pc;
`ifdef WBU_FWD_EN
   logic        pend_valid;
   logic [4:0]  pend_rd;
`endif

   always #5 clk = ~clk;

   wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .in_pc_i        (in_pc),
      .in_rd_i        (in_rd),
      .in_rd_wen_i    (in_rd_wen),
      .in_sel_i       (in_sel),
      .in_alu_result_i(in_alu_result),
      .in_mem_op_i    (in_mem_op),
      .mem_rvalid_i   (mem_rvalid),
      .mem_rdata_i    (mem_rdata),
      .rf_wen_o       (rf_wen),
      .rf_rd_o        (rf_rd),
      .rf_wdata_o     (rf_wdata),
      .commit_valid_o (commit_valid),
      .commit_pc_o    (commit_pc)
`ifdef WBU_FWD_EN
      ,
      .pend_valid_o   (pend_valid),
      .pend_rd_o      (pend_rd)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [2:0]  op;
      logic [31:0] rdata;
      int unsigned delay;
   } inst_t;

   typedef struct {
      int unsigned at;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
   } exp_t;

   inst_t       dir_q[$];
   exp_t        exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   int unsigned cyc = 0;
   bit          outstanding = 0;
   bit          holding = 0;
   bit          random_en = 0;
   inst_t       cur;
   inst_t       cur_load;
   int unsigned wait_cnt = 0;
   logic [4:0]  last_rd = '0;
   logic [31:0] last_data = '0;
   logic [31:0] last_pc = '0;
   logic [4:0]  last_cap_rd = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                            input logic [2:0] op);
      int unsigned off = int'(addr[1:0]);
      logic [31:0] b = (w >> (8 * off)) & 32'hFF;
      logic [31:0] h = (w >> (addr[1] ? 16 : 0)) & 32'hFFFF;
      case (op)
         3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
         3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic inst_t rand_inst();
      inst_t i;
      i.pc    = $urandom & 32'hFFFF_FFFC;
      i.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      i.wen   = ($urandom_range(0, 3) != 0);
      i.sel   = 2'($urandom_range(0, 3));
      i.alu   = $urandom;
      i.op    = 3'($urandom_range(0, 7));
      i.rdata = $urandom;
      i.delay = $urandom_range(1, 5);
      return i;
   endfunction

   function automatic inst_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [2:0] op,
                                input int unsigned delay);
      inst_t i;
      i.pc = pc; i.rd = rd; i.wen = 1'b1; i.sel = sel; i.alu = alu; i.op = op;
      i.rdata = 32'h80FF_7F01; i.delay = delay;
      return i;
   endfunction

   task automatic monitor();
      exp_t e;
      check_eq("in_ready", in_ready, !outstanding);
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
         e = exp_q.pop_front();
         check_eq("commit_valid", commit_valid, 1'b1);
         check_eq("commit_pc", commit_pc, e.pc);
         check_eq("rf_wen", rf_wen, e.wen && (e.rd != 0));
         check_eq("rf_rd", rf_rd, e.rd);
         check_eq("rf_wdata", rf_wdata, e.data);
         last_rd = e.rd; last_data = e.data; last_pc = e.pc;
`ifdef WBU_FWD_EN
         check_eq("pend_valid_wr", pend_valid, e.wen && (e.rd != 0));
`endif
      end else begin
         check_eq("commit_idle", commit_valid, 1'b0);
         check_eq("rf_wen_idle", rf_wen, 1'b0);
         check_eq("rf_rd_hold", rf_rd, last_rd);
         check_eq("rf_wdata_hold", rf_wdata, last_data);
         check_eq("commit_pc_hold", commit_pc, last_pc);
`ifdef WBU_FWD_EN
         check_eq("pend_valid", pend_valid, outstanding && cur_load.wen && (cur_load.rd != 0));
`endif
      end
`ifdef WBU_FWD_EN
      check_eq("pend_rd", pend_rd, last_cap_rd);
`endif
   endtask

   // One clock: check at the falling edge, drive, advance the model at the rising edge.
   task automatic step();
      bit   ready_pre;
      exp_t e;
      monitor();
      if (!holding) begin
         if (dir_q.size() > 0) begin
            cur = dir_q.pop_front();
            holding = 1;
         end else if (random_en && $urandom_range(0, 3) != 0) begin
            cur = rand_inst();
            holding = 1;
         end
      end
      in_valid      = holding;
      in_pc         = cur.pc;
      in_rd         = cur.rd;
      in_rd_wen     = cur.wen;
      in_sel        = cur.sel;
      in_alu_result = cur.alu;
      in_mem_op     = cur.op;
      if (outstanding) begin
         mem_rvalid = (wait_cnt == 1);
         mem_rdata  = mem_rvalid ? cur_load.rdata : $urandom;
      end else begin
         mem_rvalid = ($urandom_range(0, 7) == 0);
         mem_rdata  = $urandom;
      end
      ready_pre = !outstanding;
      @(posedge clk);
      cyc++;
      if (outstanding) begin
         if (mem_rvalid) begin
            outstanding = 0;
            e.at = cyc; e.pc = cur_load.pc; e.rd = cur_load.rd; e.wen = cur_load.wen;
            e.data = ref_load(mem_rdata, cur_load.alu, cur_load.op);
            exp_q.push_back(e);
         end else begin
            wait_cnt--;
         end
      end
      if (holding && ready_pre) begin
         holding = 0;
         last_cap_rd = cur.rd;
         if (cur.sel == 2'd1) begin
            outstanding = 1;
            cur_load = cur;
            wait_cnt = cur.delay;
         end else begin
            e.at = cyc; e.pc = cur.pc; e.rd = cur.rd; e.wen = cur.wen;
            e.data = (cur.sel == 2'd2) ? cur.pc + 32'd4 : cur.alu;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      rst_n = 1'b0; in_valid = 0; in_pc = '0; in_rd = '0; in_rd_wen = 0; in_sel = '0;
      in_alu_result = '0; in_mem_op = '0; mem_rvalid = 0; mem_rdata = '0;
      cur = mk(32'h0, 5'd0, 2'd0, 32'h0, 3'd0, 1);
      cur_load = cur;
      repeat (2) @(negedge clk);
      check_eq("rst_rf_wen", rf_wen, 1'b0);
      check_eq("rst_commit", commit_valid, 1'b0);
      check_eq("rst_rf_rd", rf_rd, 5'd0);
      check_eq("rst_wdata", rf_wdata, 32'd0);
      check_eq("rst_commit_pc", commit_pc, 32'd0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;

      dir_q.push_back(mk(32'h0000_0100, 5'd5, 2'd0, 32'h0000_1234, 3'd0, 1));
      dir_q.push_back(mk(32'h8000_0000, 5'd0, 2'd2, 32'h0, 3'd0, 1));
      dir_q.push_back(mk(32'h8000_0000, 5'd1, 2'd2, 32'h0, 3'd0, 1));
      dir_q.push_back(mk(32'h0000_0200, 5'd6, 2'd1, 32'h0000_1002, 3'd0, 1));
      dir_q.push_back(mk(32'h0000_0204, 5'd7, 2'd1, 32'h0000_1003, 3'd4, 1));
      dir_q.push_back(mk(32'h0000_0208, 5'd8, 2'd1, 32'h0000_1000, 3'd1, 1));
      dir_q.push_back(mk(32'h0000_020C, 5'd9, 2'd1, 32'h0000_1002, 3'd1, 2));
      dir_q.push_back(mk(32'h0000_0210, 5'd10, 2'd1, 32'h0000_1002, 3'd5, 1));
      dir_q.push_back(mk(32'h0000_0214, 5'd11, 2'd1, 32'h0000_1000, 3'd2, 4));
      dir_q.push_back(mk(32'h0000_0300, 5'd1, 2'd0, 32'h0000_0011, 3'd0, 1));
      dir_q.push_back(mk(32'h0000_0304, 5'd2, 2'd3, 32'h0000_0022, 3'd0, 1));
      dir_q.push_back(mk(32'h0000_0308, 5'd3, 2'd0, 32'h0000_0033, 3'd0, 1));
      while (dir_q.size() > 0 || holding) step();

      random_en = 1;
      repeat (3000) step();
      random_en = 0;
      n = 0;
      while ((holding || outstanding || exp_q.size() > 0) && n < 60) begin
         step();
         n++;
      end
      check_eq("drain_pending", exp_q.size(), 0);

      // Reset while a load is waiting for data.
      dir_q.push_back(mk(32'h0000_0400, 5'd12, 2'd1, 32'h0000_2000, 3'd2, 30));
      repeat (3) step();
      check_eq("pre_rst_waiting", outstanding, 1'b1);
      in_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_rf_wen", rf_wen, 1'b0);
      check_eq("rst_mid_commit", commit_valid, 1'b0);
      check_eq("rst_mid_rf_rd", rf_rd, 5'd0);
      check_eq("rst_mid_in_ready", in_ready, 1'b1);
`ifdef WBU_FWD_EN
      check_eq("rst_mid_pend_valid", pend_valid, 1'b0);
`endif
      outstanding = 0; holding = 0; exp_q.delete();
      last_rd = '0; last_data = '0; last_pc = '0; last_cap_rd = '0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_eq("post_rst_rf_wen", rf_wen, 1'b0);
      check_eq("post_rst_commit", commit_valid, 1'b0);
      check_eq("post_rst_in_ready", in_ready, 1'b1);
`ifdef WBU_FWD_EN
      check_eq("post_rst_pend_valid", pend_valid, 1'b0);
`endif
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wbu.md
# wbu

Writeback unit of the multi-cycle NPC core: accepts one retiring instruction from the execute stage per valid/ready handshake, waits for load data when needed, and produces the single-cycle write pulse (rf_wen/rf_rd/rf_wdata) that drives the register file write port. It owns:
- load sign/zero extension and byte/half alignment;
- PC+4 link value selection;
- the commit pulse consumed by difftest.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, data/PC width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  execute stage has a retiring instruction
- in_ready  out  1  wbu can capture this cycle
- in_pc  in  DATA_WIDTH  instruction PC
- in_rd  in  ADDR_WIDTH  destination register
- in_rd_wen  in  1  instruction writes rd
- in_sel  in  2  result source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU)
- in_alu_result  in  DATA_WIDTH  ALU result / load effective address
- in_mem_op  in  3  load funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
- mem_rvalid  in  1  load data response valid (single-cycle pulse)
- mem_rdata  in  DATA_WIDTH  aligned word containing the load data
- rf_wen  out  1  register file write enable
- rf_rd  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  DATA_WIDTH  PC of the retiring instruction

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE. Reset state is IDLE.
- in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM. A handshake (in_valid && in_ready) captures pc, rd, rd_wen, sel, alu_result, mem_op, and alu_result[1:0].
- IDLE or WRITE with handshake:
  - in_sel==1 → WAIT_MEM.
  - Otherwise → WRITE, with result = alu_result (sel 0/3) or pc+4 (sel 2, modulo 2^DATA_WIDTH).
- IDLE or WRITE without handshake → IDLE.
- WAIT_MEM:
  - On mem_rvalid, result = extended load → WRITE.
  - Otherwise stay in WAIT_MEM with no timeout.
- mem_rvalid is ignored outside WAIT_MEM.
- Load extension, with off = addr[1:0]:
  - lb/lbu: byte mem_rdata[8*off+7 : 8*off].
  - lh/lhu: half selected by addr[1] only; addr[0] is ignored.
  - lw: full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Undefined funct3 (3, 6, 7) behaves as lw.
- WRITE (exactly one cycle per instruction):
  - commit_valid = 1 and commit_pc = captured pc.
  - rf_wen = rd_wen && (rd != 0); rf_rd = rd; rf_wdata = result.
  - Writes to x0 are suppressed at this stage.
- Outside WRITE: rf_wen = 0 and commit_valid = 0. rf_rd, rf_wdata and commit_pc hold their last values.
- Back-to-back: a handshake in WRITE captures the next instruction on the same edge the current one leaves WRITE.

## Timing
- All outputs are registered state or decoded from state; there is no combinational path from in_* to rf_*.
- in_ready depends only on state.
- ALU/PC+4 instruction handshaken at edge E:
  - rf_wen high in cycle E..E+1.
  - Register file commits at edge E+1.
  - Sustained throughput: 1 instruction/cycle.
- Load handshaken at edge E, mem_rvalid sampled high at edge E+k (k≥1): rf_wen high in cycle E+k..E+k+1.
- Asynchronous reset (rst_n low, any time including mid-load):
  - state = IDLE; all outputs 0 (in_ready=1 once released).
  - Captured instruction discarded, no write pulse.
  - A mem_rvalid arriving after release is ignored.
- Reset release is synchronised externally; wbu requires no extra cycles after rst_n rises.

## Configuration
- WBU_FWD_EN defined: adds outputs
  - pend_valid (1): high in WAIT_MEM and WRITE when rd_wen && rd!=0.
  - pend_rd (ADDR_WIDTH): captured rd, reset 0.
  - Decode uses them for RAW stall detection against the in-flight write.
- WBU_FWD_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- ALU writeback: handshake sel=0, rd=5, alu=0x1234 → next cycle rf_wen=1, rf_rd=5, rf_wdata=0x1234, commit_valid=1, commit_pc=in_pc; following cycle rf_wen=0.
- x0 suppression and link: sel=2, rd=0, pc=0x80000000 → commit_valid=1, rf_wen=0. Repeat with rd=1 → rf_wdata=0x80000004.
- Load extension, mem_rdata=0x80FF7F01:
  - lb addr[1:0]=2 → 0xFFFFFFFF.
  - lbu addr[1:0]=3 → 0x00000080.
  - lh addr[1:0]=0 → 0x00007F01.
  - lh addr[1:0]=2 → 0xFFFF80FF.
  - lhu addr[1:0]=2 → 0x000080FF.
  - lw → 0x80FF7F01.
- Load wait: mem_rvalid delayed 4 cycles → in_ready=0 for those cycles, in_valid held without capture, write pulse exactly one cycle after mem_rvalid edge. Spurious mem_rvalid in IDLE → no write.
- Back-to-back: 3 ALU instructions with in_valid held high → rf_wen high 3 consecutive cycles with rd 1,2,3 in order, 3 commit pulses.
- Reset mid-load: assert rst_n=0 in WAIT_MEM, release, then pulse mem_rvalid → no rf_wen, no commit_valid, in_ready=1. With WBU_FWD_EN, pend_valid=0 after reset.
